// File: rtl/rv32i_types.sv
// Shared RV32I types: opcodes plus the branch-resolution queue entry and FSM state.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode;

  // Widest predictor index a queue entry can carry; narrower indices are zero-extended.
  localparam int unsigned BR_IDX_MAX = 16;

  typedef struct packed {
    logic                  pred;
    logic [BR_IDX_MAX-1:0] pred_idx;
    logic [31:0]           pc;
  } br_entry_t;

  typedef enum logic {
    BRC_RUN     = 1'b0,
    BRC_RECOVER = 1'b1
  } brc_state_t;

  function automatic logic [31:0] fall_through(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_fifo.sv
// Circular buffer of in-flight branches with head/tail pointers and occupancy count.
module br_fifo
  import rv32i_types::*;
#(
  parameter int unsigned depth = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    clear,
  input  br_entry_t               wr_entry,
  output br_entry_t               head,
  output logic [$clog2(depth):0]  count
);

  localparam int unsigned PW = $clog2(depth);
  localparam int unsigned CW = PW + 1;

  br_entry_t         mem [depth];
  logic [PW-1:0]     head_ptr;
  logic [PW-1:0]     tail_ptr;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[tail_ptr] <= wr_entry;
  end

  assign head = mem[head_ptr];

endmodule

// File: rtl/branch_resolve_ctrl.sv
// In-order branch resolution: trains the predictor, detects mispredicts and
// drives a one-cycle flush/redirect while squashing the younger in-flight branches.
module branch_resolve_ctrl
  import rv32i_types::*;
#(
  parameter int unsigned idx_size = 4,
  parameter int unsigned depth    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic                id_is_br,
  input  logic                id_pred,
  input  logic [idx_size-1:0] id_pred_idx,
  input  logic [31:0]         id_pc,
  output logic                id_stall,
  input  logic                ex_br_valid,
  input  logic                ex_taken,
  input  logic [31:0]         ex_target,
  output logic                pred_update,
  output logic                pred_taken,
  output logic [idx_size-1:0] pred_update_idx,
  output logic                flush,
  output logic                redirect_valid,
  output logic [31:0]         redirect_pc,
  output logic [31:0]         br_count,
  output logic [31:0]         mispred_count,
  output logic                err
);

  localparam int unsigned CW = $clog2(depth) + 1;

  brc_state_t      state;
  br_entry_t       head;
  br_entry_t       wr_entry;
  logic [CW-1:0]   count;
  logic            deq;
  logic            mispredict;
  logic            enq;
  logic            bad_resolve;

  assign id_stall    = (count == CW'(depth)) || (state == BRC_RECOVER);
  assign deq         = ex_br_valid && (count != '0) && (state == BRC_RUN);
  assign bad_resolve = ex_br_valid && !deq;
  assign mispredict  = deq && (ex_taken != head.pred);
  // A branch arriving alongside a mispredict is younger, so it is dropped too.
  assign enq         = id_valid && id_is_br && !id_stall && !mispredict;

  assign wr_entry = '{pred: id_pred, pred_idx: BR_IDX_MAX'(id_pred_idx), pc: id_pc};

  br_fifo #(
    .depth (depth)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (enq),
    .pop      (deq),
    .clear    (mispredict),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= BRC_RUN;
      pred_update     <= 1'b0;
      pred_taken      <= 1'b0;
      pred_update_idx <= '0;
      flush           <= 1'b0;
      redirect_valid  <= 1'b0;
      redirect_pc     <= '0;
      br_count        <= '0;
      mispred_count   <= '0;
      err             <= 1'b0;
    end else begin
      pred_update    <= deq;
      flush          <= mispredict;
      redirect_valid <= mispredict;

      if (deq) begin
        pred_taken      <= ex_taken;
        pred_update_idx <= idx_size'(head.pred_idx);
        if (br_count != '1) br_count <= br_count + 32'd1;
      end

      if (mispredict) begin
        redirect_pc <= ex_taken ? ex_target : fall_through(head.pc);
        if (mispred_count != '1) mispred_count <= mispred_count + 32'd1;
      end

      if (bad_resolve) err <= 1'b1;

      case (state)
        BRC_RUN:     if (mispredict) state <= BRC_RECOVER;
        BRC_RECOVER: state <= BRC_RUN;
        default:     state <= BRC_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed scenarios plus random traffic against a queue model.
module tb_branch_resolve_ctrl;

  localparam int unsigned IDX   = 4;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            id_valid, id_is_br, id_pred;
  logic [IDX-1:0]  id_pred_idx;
  logic [31:0]     id_pc;
  logic            id_stall;
  logic            ex_br_valid, ex_taken;
  logic [31:0]     ex_target;
  logic            pred_update, pred_taken;
  logic [IDX-1:0]  pred_update_idx;
  logic            flush, redirect_valid;
  logic [31:0]     redirect_pc, br_count, mispred_count;
  logic            err;

  branch_resolve_ctrl #(.idx_size(IDX), .depth(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_is_br(id_is_br), .id_pred(id_pred),
    .id_pred_idx(id_pred_idx), .id_pc(id_pc), .id_stall(id_stall),
    .ex_br_valid(ex_br_valid), .ex_taken(ex_taken), .ex_target(ex_target),
    .pred_update(pred_update), .pred_taken(pred_taken),
    .pred_update_idx(pred_update_idx), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .br_count(br_count), .mispred_count(mispred_count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           pred;
    logic [IDX-1:0] idx;
    logic [31:0]    pc;
  } m_entry_t;

  m_entry_t    mq[$];
  bit          m_recover;
  logic        e_pu, e_pt, e_flush, e_err;
  logic [IDX-1:0] e_idx;
  logic [31:0] e_rpc, e_brc, e_mpc;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_stall();
    return (mq.size() == DEPTH) || m_recover;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_recover = 0;
    e_pu = 0; e_pt = 0; e_idx = '0; e_flush = 0; e_rpc = '0;
    e_brc = '0; e_mpc = '0; e_err = 0;
  endtask

  // Applies one clock of the resolution rules to the current inputs.
  task automatic model_step();
    bit stall, resolve, mis, push;
    m_entry_t hd;
    stall   = m_stall();
    resolve = ex_br_valid && mq.size() > 0 && !m_recover;
    mis     = 0;
    e_pu    = resolve;
    if (resolve) begin
      hd    = mq[0];
      e_pt  = ex_taken;
      e_idx = hd.idx;
      mis   = (ex_taken != hd.pred);
      if (e_brc != 32'hFFFF_FFFF) e_brc++;
      if (mis) begin
        e_rpc = ex_taken ? ex_target : hd.pc + 32'd4;
        if (e_mpc != 32'hFFFF_FFFF) e_mpc++;
      end
    end
    if (ex_br_valid && !resolve) e_err = 1;
    e_flush = mis;
    push = id_valid && id_is_br && !stall && !mis;
    if (mis) mq.delete();
    else begin
      if (resolve) void'(mq.pop_front());
      if (push) mq.push_back('{pred: id_pred, idx: id_pred_idx, pc: id_pc});
    end
    m_recover = mis;
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".id_stall"}, 32'(id_stall), 32'(m_stall()));
    chk({ph, ".pred_update"}, 32'(pred_update), 32'(e_pu));
    chk({ph, ".pred_taken"}, 32'(pred_taken), 32'(e_pt));
    chk({ph, ".pred_update_idx"}, 32'(pred_update_idx), 32'(e_idx));
    chk({ph, ".flush"}, 32'(flush), 32'(e_flush));
    chk({ph, ".redirect_valid"}, 32'(redirect_valid), 32'(e_flush));
    chk({ph, ".redirect_pc"}, redirect_pc, e_rpc);
    chk({ph, ".br_count"}, br_count, e_brc);
    chk({ph, ".mispred_count"}, mispred_count, e_mpc);
    chk({ph, ".err"}, 32'(err), 32'(e_err));
  endtask

  task automatic set_idle();
    id_valid = 0; id_is_br = 0; id_pred = 0; id_pred_idx = '0; id_pc = '0;
    ex_br_valid = 0; ex_taken = 0; ex_target = '0;
  endtask

  task automatic cyc(input string ph);
    model_step();
    @(posedge clk);
    #1;
    check_all(ph);
    set_idle();
  endtask

  task automatic enq_br(input logic p, input logic [IDX-1:0] ix, input logic [31:0] pc);
    id_valid = 1; id_is_br = 1; id_pred = p; id_pred_idx = ix; id_pc = pc;
  endtask

  task automatic resolve(input logic t, input logic [31:0] tgt);
    ex_br_valid = 1; ex_taken = t; ex_target = tgt;
  endtask

  task automatic do_reset();
    rst = 1;
    set_idle();
    @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    rst = 0;
  endtask

  initial begin
    set_idle();
    model_reset();
    do_reset();

    // Correct prediction trains the predictor, no flush.
    enq_br(1, 4'd3, 32'h100); cyc("r21_enq");
    resolve(1, 32'h180);      cyc("r21_res");
    chk("r21.pred_update", 32'(pred_update), 32'd1);
    chk("r21.idx", 32'(pred_update_idx), 32'd3);
    chk("r21.br_count", br_count, 32'd1);
    cyc("r21_after");

    // Not-taken prediction resolved taken redirects to the target.
    enq_br(0, 4'd5, 32'h200); cyc("r22_enq");
    resolve(1, 32'h240);      cyc("r22_res");
    chk("r22.redirect_pc", redirect_pc, 32'h240);
    chk("r22.flush", 32'(flush), 32'd1);
    chk("r22.mispred_count", mispred_count, 32'd1);
    cyc("r22_recover");
    chk("r22.flush_drop", 32'(flush), 32'd0);

    // Mispredict squashes younger entries and redirects to pc+4.
    enq_br(1, 4'd1, 32'h300); cyc("r23_e0");
    enq_br(0, 4'd2, 32'h304); cyc("r23_e1");
    enq_br(1, 4'd7, 32'h308); cyc("r23_e2");
    resolve(0, 32'hDEAD_0000); enq_br(1, 4'd9, 32'h30C); cyc("r23_res");
    chk("r23.redirect_pc", redirect_pc, 32'h304);
    chk("r23.id_stall", 32'(id_stall), 32'd1);
    cyc("r23_rec");
    chk("r23.id_stall_clear", 32'(id_stall), 32'd0);

    // Fill to depth, reject fifth, then drain one.
    for (int i = 0; i < 4; i++) begin
      enq_br(1, 4'(i), 32'h400 + 32'(i) * 4); cyc("r24_fill");
    end
    chk("r24.stall_full", 32'(id_stall), 32'd1);
    enq_br(0, 4'hF, 32'h4F0); cyc("r24_fifth");
    resolve(1, 32'h500); enq_br(0, 4'hE, 32'h4E0); cyc("r24_deq");
    chk("r24.stall_relaxed", 32'(id_stall), 32'd0);
    for (int i = 0; i < 4; i++) begin
      resolve(1, 32'h600); cyc("r24_drain");
    end
    chk("r24.idx_last", 32'(pred_update_idx), 32'd3);

    // Resolve with empty queue: sticky error, no training.
    do_reset();
    resolve(1, 32'h700); cyc("r25_empty");
    chk("r25.err", 32'(err), 32'd1);
    chk("r25.no_update", 32'(pred_update), 32'd0);
    cyc("r25_hold");
    cyc("r25_hold2");
    do_reset();
    chk("r25.err_cleared", 32'(err), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 6) begin
        enq_br(1'($urandom_range(0, 1)), 4'($urandom), $urandom & 32'hFFFF_FFFC);
        id_is_br = ($urandom_range(0, 9) < 8);
      end
      if ($urandom_range(0, 9) < 4) begin
        ex_br_valid = 1;
        ex_target   = $urandom;
        if (mq.size() > 0 && $urandom_range(0, 9) < 7) ex_taken = mq[0].pred;
        else ex_taken = 1'($urandom_range(0, 1));
      end
      cyc("rand");
    end

    // Asynchronous reset during the flush pulse cancels it at once.
    do_reset();
    enq_br(0, 4'd6, 32'h800); cyc("r26_enq");
    resolve(1, 32'h880);      cyc("r26_res");
    chk("r26.flush_high", 32'(flush), 32'd1);
    #2;
    rst = 1;
    #1;
    model_reset();
    check_all("r26_async");
    @(posedge clk);
    #1;
    rst = 0;
    cyc("r26_post");
    cyc("r26_post2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 SHALL have parameter idx_size, default 4, predictor index width.
REQ-002 SHALL have parameter depth, default 4, power of two, in-flight branch queue entries.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  ID-stage instruction valid.
- id_is_br  in  1  ID instruction opcode is op_br.
- id_pred  in  1  predictor direction for ID branch.
- id_pred_idx  in  idx_size  predictor index used.
- id_pc  in  32  branch PC.
- id_stall  out  1  queue cannot accept (full or RECOVER).
- ex_br_valid  in  1  oldest in-flight branch resolved this cycle.
- ex_taken  in  1  actual direction.
- ex_target  in  32  actual taken target.
- pred_update  out  1  predictor training strobe.
- pred_taken  out  1  training direction.
- pred_update_idx  out  idx_size  training index.
- flush  out  1  squash younger IF/ID work.
- redirect_valid  out  1  fetch redirect strobe.
- redirect_pc  out  32  fetch redirect address.
- br_count  out  32  resolved branches.
- mispred_count  out  32  mispredicted branches.
- err  out  1  sticky protocol error.

Function
REQ-004 SHALL hold a FIFO of depth entries {pred, pred_idx, pc}, with head/tail pointers and a count of width clog2(depth)+1.
REQ-005 SHALL enqueue when id_valid && id_is_br && !id_stall; id_stall = (count == depth) || state == RECOVER, combinational.
REQ-006 SHALL dequeue the head when ex_br_valid and count > 0; resolution is strictly in order.
REQ-007 SHALL register pred_update=1, pred_taken=ex_taken and pred_update_idx=head.pred_idx on the edge after each dequeue (1-cycle latency, 1-cycle pulse).
REQ-008 SHALL compute mispredict = ex_taken != head.pred at dequeue.
REQ-009 On mispredict, SHALL pulse flush and redirect_valid together for exactly one cycle, registered, with redirect_pc = ex_target if ex_taken, else head.pc + 4 (32-bit wrap).
REQ-010 On mispredict, SHALL empty the FIFO (all remaining entries are younger) and enter RECOVER for one cycle, then return to RUN.
REQ-011 FSM SHALL have states RUN and RECOVER only: RUN->RECOVER on mispredict; RECOVER->RUN unconditionally.
REQ-012 Simultaneous enqueue and mispredicting dequeue: enqueue SHALL be discarded.
REQ-013 Simultaneous enqueue and correct dequeue with FIFO full: both SHALL occur only if id_stall was low; id_stall is not relaxed by the same-cycle dequeue.
REQ-014 ex_br_valid in RECOVER or with count == 0 SHALL be ignored for FIFO, training and counters and SHALL set err until reset.
REQ-015 br_count SHALL increment per valid dequeue; mispred_count per mispredict; both saturate at 32'hFFFF_FFFF.
REQ-016 Pointers SHALL wrap modulo depth.

Reset
REQ-017 While rst is high: FIFO empty, state RUN; id_stall, pred_update, pred_taken, flush, redirect_valid and err = 0; pred_update_idx = 0, redirect_pc = 0; counters = 0.
REQ-018 Reset asserted mid-recovery SHALL cancel any pending flush/redirect pulse immediately; no pulse after deassertion.

Structure
REQ-019 SHALL import rv32i_types; the queue-entry struct br_entry_t and the state enum brc_state_t SHALL be added to that package.
REQ-020 SHALL instantiate one sub-module, br_fifo, holding the circular buffer and pointers; FSM, compare and counters stay in the top.

Verification
REQ-021 Enqueue pc=0x100, pred=1, idx=3; resolve ex_taken=1 -> next cycle pred_update=1, pred_taken=1, idx=3; no flush; br_count=1.
REQ-022 Enqueue pc=0x200, pred=0; resolve ex_taken=1, ex_target=0x240 -> flush=redirect_valid=1 for 1 cycle, redirect_pc=0x240; mispred_count=1.
REQ-023 Enqueue pc=0x300, pred=1, plus 2 younger branches; resolve not-taken -> redirect_pc=0x304, FIFO count=0, id_stall=1 for one cycle.
REQ-024 Enqueue 4 branches (depth=4) -> id_stall=1; fifth id_valid branch not stored; dequeue one -> id_stall=0 next cycle.
REQ-025 ex_br_valid with empty FIFO -> no pred_update, counters unchanged, err=1 until rst.
REQ-026 Assert rst asynchronously the cycle after a mispredict -> flush and redirect_valid drop immediately; all outputs at reset values.
